// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Parametrised register file: two combinational read ports, one synchronous
//   write port and a per-register pending (scoreboard) bit. Decode marks a
//   destination pending with SEN; writeback writes the result and clears it.
//
// Parameters:
//   DATA_W   - register width
//   ADDR_W   - address width (depth = 2**ADDR_W, derived)
//   ZERO_REG - 1: register 0 reads zero, ignores writes and SEN
//
// Ports:
//   Clk, rst_n        - clock (rising edge), synchronous active-low reset
//   WEN, RW, busW     - write enable / address / data
//   RX, RY            - read addresses
//   busX, busY        - read data (combinational)
//   SEN, RS           - mark register RS pending
//   FLUSH             - clear all pending bits (register write still occurs)
//   busyX, busyY      - pending bit of RX / RY (combinational)
//   anyBusy           - OR of all pending bits (combinational)
//
// Optional feature macro: REGFILE_BYPASS_EN
//   Defined: same-cycle write data is forwarded to the read ports.
//   Undefined: reads return stored state only.
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              Clk,
    input  logic              rst_n,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] RW,
    input  logic [DATA_W-1:0] busW,
    input  logic [ADDR_W-1:0] RX,
    input  logic [ADDR_W-1:0] RY,
    output logic [DATA_W-1:0] busX,
    output logic [DATA_W-1:0] busY,
    input  logic              SEN,
    input  logic [ADDR_W-1:0] RS,
    input  logic              FLUSH,
    output logic              busyX,
    output logic              busyY,
    output logic              anyBusy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic              wen_eff;
    logic              sen_eff;

    // Qualify write/set requests: register 0 is immutable when hardwired
    always_comb begin
        wen_eff = WEN;
        sen_eff = SEN;
        if (ZERO_REG != 0) begin
            if (RW == '0) wen_eff = 1'b0;
            if (RS == '0) sen_eff = 1'b0;
        end
    end

    // Next state: write clears pending, a same-cycle SEN re-sets it,
    // and FLUSH wins over both for the pending bits only
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wen_eff) begin
            regs_d[RW] = busW;
            pend_d[RW] = 1'b0;
        end
        if (sen_eff) begin
            pend_d[RS] = 1'b1;
        end
        if (FLUSH) begin
            pend_d = '0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    // Read port X
    always_comb begin
        busX  = regs_q[RX];
        busyX = pend_q[RX];
`ifdef REGFILE_BYPASS_EN
        if (wen_eff && (RW == RX)) begin
            busX  = busW;
            busyX = sen_eff && (RS == RX);
        end
`endif
        if ((ZERO_REG != 0) && (RX == '0)) begin
            busX  = '0;
            busyX = 1'b0;
        end
    end

    // Read port Y
    always_comb begin
        busY  = regs_q[RY];
        busyY = pend_q[RY];
`ifdef REGFILE_BYPASS_EN
        if (wen_eff && (RW == RY)) begin
            busY  = busW;
            busyY = sen_eff && (RS == RY);
        end
`endif
        if ((ZERO_REG != 0) && (RY == '0)) begin
            busY  = '0;
            busyY = 1'b0;
        end
    end

    assign anyBusy = |pend_q;

endmodule
